mem_arbiter: RTL
================

# mem_arbiter

Two-port round-robin arbiter that shares the CPU's single-port synchronous data memory between the multi-cycle CPU controller (port 0) and a secondary requester such as a program loader or debug/DMA engine (port 1). It sits between the requesters and the memory, serialises their accesses with a req/ack handshake, and returns read data per port. One transaction completes every 4 cycles.

## Interface
- AW, 8, memory address width
- DW, 16, data width
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req0 / req1  in  1  access request, level; held until ack
- we0 / we1  in  1  1 = write, 0 = read; valid with req
- addr0 / addr1  in  AW  access address
- wdata0 / wdata1  in  DW  write data
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata0 / rdata1  out  DW  read data, valid while ack high and held afterwards
- mem_en  out  1  memory access strobe, one cycle per transaction
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid the cycle after mem_en
- busy  out  1  high in any state other than IDLE
- last_grant  out  1  port granted most recently

## Operation
- FSM: IDLE -> ACCESS -> RESP -> ACK -> IDLE. No other transitions except reset.
- IDLE: if neither req high, stay. If exactly one high, grant it. If both high, grant port != last_grant. On grant: latch port, we, addr, wdata into registered mem_* outputs, set mem_en, update last_grant, go ACCESS.
- ACCESS: mem_en high for this cycle only; memory samples at its end. Go RESP.
- RESP: mem_en low; mem_rdata valid. For a read, capture mem_rdata into granted port's rdata; for a write, rdata unchanged. Set granted ack. Go ACK.
- ACK: granted ack high for exactly this cycle; both reqs ignored. Go IDLE.
- Requester drops req, or changes addr/we/wdata for the next access, at the edge ending ACK. req still high in the following IDLE is treated as a new request.
- addr/we/wdata are sampled only at the grant edge; later changes do not affect the transaction.
- Non-granted port's req is ignored until the next IDLE; a port that keeps req high alternates with the other under contention.
- Reset values: state IDLE, ack0/ack1 0, rdata0/rdata1 0, mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0, busy 0, last_grant 1, so port 0 wins the first tie.
- Reset mid-transaction: returns to IDLE next cycle with no ack. A write already strobed in ACCESS may have completed; the requester must reissue.

## Timing
- req high in cycle T (IDLE): mem_en high T+1, mem_rdata valid T+2, ack and rdata visible T+3. Latency is 3 cycles from req to ack.
- Back-to-back throughput is one transaction per 4 cycles. Next grant is earliest at T+4.
- All outputs are registered; there is no combinational path from req/addr to any output.

## Configuration
- MEM_ARB_STAT_EN defined: adds outputs grant_cnt0 and grant_cnt1, each out 16. Each counter increments on its port's grant edge, saturates at 0xFFFF, and resets to 0.
- MEM_ARB_STAT_EN undefined: these ports and counters do not exist. All other behaviour is identical.

## Structure
- Shared package mem_arb_pkg holds:
  - state encoding constants IDLE=2'd0, ACCESS=2'd1, RESP=2'd2, ACK=2'd3
  - default AW/DW constants
- Sub-module mem_arb_rr_pick: combinational 2-input round-robin picker. Inputs are req0, req1 and last_grant; outputs are grant_valid and grant_port. It is instantiated once.

## Test plan
- Reset: after reset, all outputs read their reset values (last_grant=1, busy=0, mem_en=0, acks=0, rdata=0).
- Single read: memory holds 0xBEEF at 0x05; req0 read addr 0x05 at T -> mem_en/mem_addr=0x05 at T+1, ack0 pulse and rdata0=0xBEEF at T+3, ack1 stays 0.
- Write then readback: port1 writes 0x1234 to 0x10 -> ack1 at T+3, rdata1 unchanged. A following port1 read of 0x10 returns 0x1234.
- Contention: req0 and req1 both raised together after reset and held -> grant order is port 0, port 1, port 0, port 1, with acks 4 cycles apart.
- Reset in ACCESS: assert reset during the ACCESS cycle of a port0 read -> next cycle IDLE, no ack0, mem_en 0.
- MEM_ARB_STAT_EN: 3 port0 and 2 port1 transactions -> grant_cnt0=3 and grant_cnt1=2. After reset both counters are 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter: FSM state encoding
// and default address/data widths.
package mem_arb_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    ACK    = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational two-input round-robin picker: on a tie the port that did not
// win last time is chosen.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_port
);

  always_comb begin
    grant_valid = req0 | req1;
    grant_port  = 1'b0;
    if (req0 && req1) begin
      grant_port = ~last_grant;
    end else if (req1) begin
      grant_port = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing a single-port synchronous memory between two
// requesters. Define MEM_ARB_STAT_EN to add per-port saturating grant counters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
`ifdef MEM_ARB_STAT_EN
  output logic          last_grant,
  output logic [15:0]   grant_cnt0,
  output logic [15:0]   grant_cnt1
`else
  output logic          last_grant
`endif
);

  arb_state_t state, state_next;
  logic       pick_valid;
  logic       pick_port;
  logic       gnt_port;
  logic       take_grant;
  logic       capture;

  mem_arb_rr_pick u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant),
    .grant_valid(pick_valid),
    .grant_port (pick_port)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Requests are only looked at in IDLE; every other state is a fixed walk.
  always_comb begin
    state_next = state;
    take_grant = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          take_grant = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS:  state_next = RESP;
      RESP: begin
        capture    = 1'b1;
        state_next = ACK;
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_port   <= 1'b0;
      last_grant <= 1'b1;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      mem_en <= take_grant;
      ack0   <= capture && !gnt_port;
      ack1   <= capture && gnt_port;
      if (take_grant) begin
        gnt_port   <= pick_port;
        last_grant <= pick_port;
        mem_we     <= pick_port ? we1    : we0;
        mem_addr   <= pick_port ? addr1  : addr0;
        mem_wdata  <= pick_port ? wdata1 : wdata0;
      end
      // Writes leave the port's last read value in place.
      if (capture && !mem_we) begin
        if (gnt_port) begin
          rdata1 <= mem_rdata;
        end else begin
          rdata0 <= mem_rdata;
        end
      end
    end
  end

  assign busy = (state != IDLE);

`ifdef MEM_ARB_STAT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (take_grant) begin
      if (!pick_port && grant_cnt0 != 16'hFFFF) begin
        grant_cnt0 <= grant_cnt0 + 16'd1;
      end
      if (pick_port && grant_cnt1 != 16'hFFFF) begin
        grant_cnt1 <= grant_cnt1 + 16'd1;
      end
    end
  end
`endif

endmodule
